// File: rtl/irq_injector.sv
// Interrupt stimulus generator: per-channel PC-triggered interrupts with optional
// delay and pulse timeout, cleared by a store to the acknowledge address.
module irq_injector #(
  parameter int                 N_CH       = 2,
  parameter logic [N_CH*32-1:0] TRIG_PC    = {32'h00003040, 32'h00003018},
  parameter int                 FIRE_LIMIT = 1,
  parameter int                 DELAY      = 0,
  parameter int                 PULSE_LEN  = 0,
  parameter logic [31:0]        ACK_ADDR   = 32'h00007F20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     macroscopic_pc,
  input  logic [31:0]     m_data_addr,
  input  logic [3:0]      m_data_byteen,
  output logic            interrupt,
  output logic [N_CH-1:0] irq_vec,
  output logic [15:0]     ack_count,
  output logic [N_CH-1:0] timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ASSERT,
    S_RELEASE,
    S_DONE
  } state_e;

  localparam logic [7:0] LIMIT_W = 8'(FIRE_LIMIT);
  localparam logic [7:0] DELAY_W = 8'(DELAY);
  localparam logic [7:0] PULSE_W = 8'(PULSE_LEN);

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [7:0]      fires_q [N_CH];
  logic [7:0]      fires_d [N_CH];
  logic [7:0]      dcnt_q  [N_CH];
  logic [7:0]      dcnt_d  [N_CH];
  logic [7:0]      pcnt_q  [N_CH];
  logic [7:0]      pcnt_d  [N_CH];
  logic [N_CH-1:0] hit_q;
  logic [N_CH-1:0] hit_d;
  logic [N_CH-1:0] timeout_q;
  logic [N_CH-1:0] timeout_d;
  logic [15:0]     ack_count_q;
  logic [15:0]     ack_count_d;

  logic [31:0]     pc_w;
  logic [31:0]     addr_w;
  logic            ack;
  logic [N_CH-1:0] trig;
  logic [3:0]      ack_n;
  logic [16:0]     ack_sum;

  // Rising-edge PC match so a PC stalled on the trigger address fires only once
  always_comb begin
    pc_w   = macroscopic_pc & 32'hFFFF_FFFC;
    addr_w = m_data_addr & 32'hFFFF_FFFC;
    ack    = (|m_data_byteen) && (addr_w == ACK_ADDR);
    for (int i = 0; i < N_CH; i++) begin
      hit_d[i] = (pc_w == TRIG_PC[32*i +: 32]);
    end
    trig = hit_d & ~hit_q;
  end

  always_comb begin
    ack_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]   = state_q[i];
      fires_d[i]   = fires_q[i];
      dcnt_d[i]    = dcnt_q[i];
      pcnt_d[i]    = pcnt_q[i];
      timeout_d[i] = timeout_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (trig[i] && (LIMIT_W == 8'd0 || fires_q[i] < LIMIT_W)) begin
            if (DELAY_W == 8'd0) begin
              state_d[i] = S_ASSERT;
              pcnt_d[i]  = 8'd1;
            end else begin
              state_d[i] = S_WAIT;
              dcnt_d[i]  = DELAY_W;
            end
          end
        end
        S_WAIT: begin
          if (dcnt_q[i] == 8'd1) begin
            state_d[i] = S_ASSERT;
            pcnt_d[i]  = 8'd1;
          end else begin
            dcnt_d[i] = dcnt_q[i] - 8'd1;
          end
        end
        // Ack takes priority over a timeout landing on the same edge
        S_ASSERT: begin
          if (ack) begin
            state_d[i] = S_RELEASE;
            ack_n      = ack_n + 4'd1;
          end else if (PULSE_W != 8'd0 && pcnt_q[i] == PULSE_W) begin
            state_d[i]   = S_RELEASE;
            timeout_d[i] = 1'b1;
          end else begin
            pcnt_d[i] = pcnt_q[i] + 8'd1;
          end
        end
        S_RELEASE: begin
          fires_d[i] = fires_q[i] + 8'd1;
          if (LIMIT_W != 8'd0 && (fires_q[i] + 8'd1) == LIMIT_W) begin
            state_d[i] = S_DONE;
          end else begin
            state_d[i] = S_IDLE;
          end
        end
        S_DONE: begin
          state_d[i] = S_DONE;
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
    ack_sum     = {1'b0, ack_count_q} + 17'(ack_n);
    ack_count_d = ack_sum[16] ? 16'hFFFF : ack_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        fires_q[i] <= '0;
        dcnt_q[i]  <= '0;
        pcnt_q[i]  <= '0;
      end
      hit_q       <= '0;
      timeout_q   <= '0;
      ack_count_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        fires_q[i] <= fires_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
      hit_q       <= hit_d;
      timeout_q   <= timeout_d;
      ack_count_q <= ack_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      irq_vec[i] = (state_q[i] == S_ASSERT);
    end
    interrupt    = |irq_vec;
    ack_count    = ack_count_q;
    timeout_flag = timeout_q;
  end

endmodule

// File: tb/tb_irq_injector.sv
// Bench for irq_injector: six differently configured instances share one input bus
// and are compared every cycle against an event-time reference model.
module tb_irq_injector;

  localparam int          NI  = 6;
  localparam int          IA  = 0;
  localparam int          IB  = 1;
  localparam int          IC  = 2;
  localparam int          ID  = 3;
  localparam int          IE  = 4;
  localparam logic [31:0] ACK = 32'h0000_7F20;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [3:0]  byteen;

  logic [1:0]  dv [NI];
  logic        di [NI];
  logic [15:0] dc [NI];
  logic [1:0]  dt [NI];

  int checks = 0;
  int passes = 0;

  int          cfg_delay [NI] = '{0, 3, 0, 0, 0, 2};
  int          cfg_pulse [NI] = '{0, 0, 4, 0, 0, 5};
  int          cfg_limit [NI] = '{1, 1, 1, 0, 1, 3};
  logic [31:0] cfg_pc    [NI][2];

  // Model: each channel tracked by edge timestamps instead of a state machine
  bit          m_on    [NI][2];
  bit          m_prev  [NI][2];
  int          m_since [NI][2];
  int          m_rise  [NI][2];
  int          m_rearm [NI][2];
  int          m_fires [NI][2];
  int          m_acks  [NI];
  logic [1:0]  m_to    [NI];
  int          edge_n = 0;

  always #5 clk = ~clk;

  irq_injector u_a (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[0]), .irq_vec(dv[0]), .ack_count(dc[0]), .timeout_flag(dt[0]));
  irq_injector #(.DELAY(3)) u_b (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[1]), .irq_vec(dv[1]), .ack_count(dc[1]), .timeout_flag(dt[1]));
  irq_injector #(.PULSE_LEN(4)) u_c (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[2]), .irq_vec(dv[2]), .ack_count(dc[2]), .timeout_flag(dt[2]));
  irq_injector #(.FIRE_LIMIT(0)) u_d (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[3]), .irq_vec(dv[3]), .ack_count(dc[3]), .timeout_flag(dt[3]));
  irq_injector #(.TRIG_PC({32'h0000_3018, 32'h0000_3018})) u_e (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[4]), .irq_vec(dv[4]), .ack_count(dc[4]), .timeout_flag(dt[4]));
  irq_injector #(.TRIG_PC({32'h0000_3018, 32'h0000_3040}), .FIRE_LIMIT(3), .DELAY(2),
                 .PULSE_LEN(5)) u_f (
    .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr), .m_data_byteen(byteen),
    .interrupt(di[5]), .irq_vec(dv[5]), .ack_count(dc[5]), .timeout_flag(dt[5]));

  function automatic stim_t mk(logic [31:0] p, bit a);
    stim_t s;
    s.pc   = p;
    s.addr = a ? ACK : 32'h0000_1000;
    s.be   = a ? 4'hF : 4'h0;
    return s;
  endfunction

  function automatic logic [20:0] exp_bus(int i);
    logic [1:0] v;
    v = {m_on[i][1], m_on[i][0]};
    return {v, |v, (m_acks[i] > 65535) ? 16'hFFFF : 16'(m_acks[i]), m_to[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_on[i][c]    = 1'b0;
        m_prev[i][c]  = 1'b0;
        m_since[i][c] = 0;
        m_rise[i][c]  = -1;
        m_rearm[i][c] = 0;
        m_fires[i][c] = 0;
      end
      m_acks[i] = 0;
      m_to[i]   = 2'b00;
    end
  endtask

  // Release takes the edge after ack/timeout, so the channel re-arms two edges later
  task automatic model_step();
    bit          ack;
    bit          hit;
    bit          trig;
    logic [31:0] pcw;
    pcw = pc & 32'hFFFF_FFFC;
    ack = (byteen != 4'h0) && ((addr & 32'hFFFF_FFFC) == ACK);
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        hit          = (pcw == cfg_pc[i][c]);
        trig         = hit && !m_prev[i][c];
        m_prev[i][c] = hit;
        if (m_on[i][c]) begin
          if (ack) begin
            m_on[i][c] = 1'b0;
            m_fires[i][c]++;
            m_acks[i]++;
            m_rearm[i][c] = edge_n + 2;
          end else if (cfg_pulse[i] > 0 && edge_n - m_since[i][c] == cfg_pulse[i]) begin
            m_on[i][c] = 1'b0;
            m_fires[i][c]++;
            m_to[i][c]    = 1'b1;
            m_rearm[i][c] = edge_n + 2;
          end
        end else if (m_rise[i][c] >= 0) begin
          if (edge_n == m_rise[i][c]) begin
            m_on[i][c]    = 1'b1;
            m_since[i][c] = edge_n;
            m_rise[i][c]  = -1;
          end
        end else if (trig && edge_n >= m_rearm[i][c] &&
                     (cfg_limit[i] == 0 || m_fires[i][c] < cfg_limit[i])) begin
          if (cfg_delay[i] == 0) begin
            m_on[i][c]    = 1'b1;
            m_since[i][c] = edge_n;
          end else begin
            m_rise[i][c] = edge_n + cfg_delay[i];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    model_reset();
    tick();
    tick();
    reset  = 1'b0;
    pc     = 32'h0;
    addr   = 32'h0;
    byteen = 4'h0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    pc     = 32'h0;
    addr   = 32'h0;
    byteen = 4'h0;
    model_reset();
    tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({dv[i], di[i], dc[i], dt[i]} !== 21'h0)
        $display("[TB] FAIL reset_state inst%0d: got %h want 0", i, {dv[i], di[i], dc[i], dt[i]});
      else passes++;
    end
    reset = 1'b0;
  endtask

  task automatic test_default_fire();
    stim_t q[$];
    do_reset();
    for (int p = 0; p < 7; p++) q.push_back(mk(32'h3000 + 32'(4 * p), 1'b0));
    q.push_back(mk(32'h3018, 1'b1));
    q.push_back(mk(32'h3000, 1'b0));
    q.push_back(mk(32'h3018, 1'b0));
    q.push_back(mk(32'h3018, 1'b0));
    for (int k = 0; k < q.size(); k++) begin
      pc = q[k].pc; addr = q[k].addr; byteen = q[k].be;
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL default_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
      if (k == 5 || k == 6 || k == 7 || k == 10) begin
        checks++;
        if ({dv[IA], di[IA]} !== ((k == 6) ? 3'b011 : 3'b000))
          $display("[TB] FAIL default_irq step%0d: got %b want %b", k, {dv[IA], di[IA]}, (k == 6) ? 3'b011 : 3'b000);
        else passes++;
      end
    end
    checks++;
    if (dc[IA] !== 16'd1) $display("[TB] FAIL default_ack_count: got %0d want 1", dc[IA]);
    else passes++;
  endtask

  task automatic test_delay();
    stim_t q[$];
    do_reset();
    q.push_back(mk(32'h3000, 1'b0));
    for (int k = 0; k < 5; k++) q.push_back(mk(32'h3040, 1'b0));
    q.push_back('{32'h3040, 32'h7F22, 4'b0100});
    q.push_back(mk(32'h3040, 1'b0));
    for (int k = 0; k < q.size(); k++) begin
      pc = q[k].pc; addr = q[k].addr; byteen = q[k].be;
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL delay_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
      if (k >= 1 && k <= 6) begin
        checks++;
        if (dv[IB] !== ((k == 4 || k == 5) ? 2'b10 : 2'b00))
          $display("[TB] FAIL delay_irq step%0d: got %b want %b", k, dv[IB], (k == 4 || k == 5) ? 2'b10 : 2'b00);
        else passes++;
      end
    end
    checks++;
    if (dc[IB] !== 16'd1) $display("[TB] FAIL delay_ack_count: got %0d want 1", dc[IB]);
    else passes++;
  endtask

  task automatic test_pulse_timeout();
    int highs = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      pc = (k == 0) ? 32'h3000 : 32'h3018; addr = 32'h0; byteen = 4'h0;
      tick();
      if (dv[IC][0]) highs++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL pulse_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
    end
    checks++;
    if ({highs[7:0], dt[IC], dc[IC]} !== {8'd4, 2'b01, 16'd0})
      $display("[TB] FAIL pulse_timeout: got highs=%0d flag=%b acks=%0d want 4/01/0", highs, dt[IC], dc[IC]);
    else passes++;
  endtask

  task automatic test_pulse_ack();
    stim_t q[$];
    do_reset();
    q.push_back(mk(32'h3000, 1'b0));
    for (int k = 0; k < 4; k++) q.push_back(mk(32'h3018, 1'b0));
    q.push_back(mk(32'h3018, 1'b1));
    q.push_back(mk(32'h3000, 1'b0));
    for (int k = 0; k < q.size(); k++) begin
      pc = q[k].pc; addr = q[k].addr; byteen = q[k].be;
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL pulse_ack_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
    end
    checks++;
    if ({dv[IC], dt[IC], dc[IC]} !== {2'b00, 2'b00, 16'd1})
      $display("[TB] FAIL pulse_ack_wins: got irq=%b flag=%b acks=%0d want 00/00/1", dv[IC], dt[IC], dc[IC]);
    else passes++;
  endtask

  task automatic test_unlimited();
    stim_t q[$];
    int    rises = 0;
    bit    prev  = 1'b0;
    do_reset();
    q.push_back(mk(32'h3000, 1'b0));
    for (int k = 0; k < 10; k++) q.push_back(mk(32'h3018, 1'b0));
    q.push_back(mk(32'h3018, 1'b1));
    for (int r = 0; r < 3; r++) begin
      q.push_back(mk(32'h3000, 1'b0));
      q.push_back(mk(32'h3018, 1'b0));
      q.push_back(mk(32'h3018, 1'b0));
      q.push_back(mk(32'h3018, 1'b1));
    end
    for (int k = 0; k < q.size(); k++) begin
      pc = q[k].pc; addr = q[k].addr; byteen = q[k].be;
      tick();
      if (dv[ID][0] && !prev) rises++;
      prev = dv[ID][0];
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL unlimited_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
    end
    checks++;
    if (rises != 4 || dc[ID] !== 16'd4)
      $display("[TB] FAIL unlimited_fires: got rises=%0d acks=%0d want 4/4", rises, dc[ID]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    do_reset();
    q.push_back(mk(32'h3000, 1'b0));
    q.push_back(mk(32'h3018, 1'b0));
    q.push_back(mk(32'h3018, 1'b1));
    q.push_back(mk(32'h3000, 1'b0));
    for (int k = 0; k < q.size(); k++) begin
      pc = q[k].pc; addr = q[k].addr; byteen = q[k].be;
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL shared_model inst%0d step%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
      if (k == 1) begin
        checks++;
        if ({dv[IE], di[IE]} !== 3'b111) $display("[TB] FAIL shared_both: got %b want 111", {dv[IE], di[IE]});
        else passes++;
      end
    end
    checks++;
    if ({dv[IE], dc[IE]} !== {2'b00, 16'd2})
      $display("[TB] FAIL shared_ack: got irq=%b acks=%0d want 00/2", dv[IE], dc[IE]);
    else passes++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      pc = (phase == 0) ? 32'h3040 : 32'h3018;
      tick();
      if (phase == 1) begin
        checks++;
        if (dv[IA] !== 2'b01) $display("[TB] FAIL midflight_assert: got %b want 01", dv[IA]);
        else passes++;
      end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== 21'h0)
          $display("[TB] FAIL async_reset phase%0d inst%0d: got %h want 0", phase, i, {dv[i], di[i], dc[i], dt[i]});
        else passes++;
      end
      tick();
      reset = 1'b0;
    end
    pc = 32'h3018;
    tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
        $display("[TB] FAIL refire_model inst%0d: got %h want %h", i, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
      else passes++;
    end
    checks++;
    if (dv[IA] !== 2'b01) $display("[TB] FAIL refire_after_reset: got %b want 01", dv[IA]);
    else passes++;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 5))
          0:       pc = 32'h3000;
          1:       pc = 32'h3018;
          2:       pc = 32'h3040;
          3:       pc = 32'h301A;
          4:       pc = 32'h3043;
          default: pc = $urandom;
        endcase
      end
      r = $urandom_range(0, 99);
      if (r < 12) begin
        addr = ACK | 32'($urandom_range(0, 3)); byteen = 4'($urandom_range(1, 15));
      end else if (r < 18) begin
        addr = ACK; byteen = 4'h0;
      end else if (r < 24) begin
        addr = 32'h7F24; byteen = 4'hF;
      end else begin
        addr = $urandom; byteen = 4'h0;
      end
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({dv[i], di[i], dc[i], dt[i]} !== exp_bus(i))
          $display("[TB] FAIL random_model inst%0d cycle%0d: got %h want %h", i, k, {dv[i], di[i], dc[i], dt[i]}, exp_bus(i));
        else passes++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    cfg_pc[0] = '{32'h3018, 32'h3040};
    cfg_pc[1] = '{32'h3018, 32'h3040};
    cfg_pc[2] = '{32'h3018, 32'h3040};
    cfg_pc[3] = '{32'h3018, 32'h3040};
    cfg_pc[4] = '{32'h3018, 32'h3018};
    cfg_pc[5] = '{32'h3040, 32'h3018};
    test_reset();
    test_default_fire();
    test_delay();
    test_pulse_timeout();
    test_pulse_ack();
    test_unlimited();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
